carry_bypass_adder: RTL and testbench

CARRY_BYPASS_ADDER -- requirements
Module: carry_bypass_adder

---
 rtl/carry_bypass_adder_if.sv | 34 +++
 rtl/carry_bypass_adder.sv | 75 +++++++
 tb/tb_carry_bypass_adder.sv | 106 ++++++++++
 3 files changed

// File: rtl/carry_bypass_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : carry_bypass_adder_if
// Description : Operand/result bundle for the carry-bypass adder. The
//               master drives A, B and Cin and receives F and Cout; the
//               slave (the adder) does the opposite.
// Revision    : 1.0 - initial release
// ============================================================================
interface carry_bypass_adder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] F;
  logic             Cout;

  modport master (
    output A,
    output B,
    output Cin,
    input  F,
    input  Cout
  );

  modport slave (
    input  A,
    input  B,
    input  Cin,
    output F,
    output Cout
  );
endinterface
`default_nettype wire

// File: rtl/carry_bypass_adder.sv
`default_nettype none
// ============================================================================
// Module      : carry_bypass_adder
// Description : WIDTH-bit adder built from BLOCK-bit ripple blocks with a
//               per-block carry bypass. {Cout, F} = A + B + Cin, registered
//               once (one-cycle latency, one operation per clock). Only the
//               outputs are flip-flops; the operands are used combinationally.
//               WIDTH must be an integer multiple of BLOCK.
// Revision    : 1.0 - initial release
// ============================================================================
module carry_bypass_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  wire                   clk,
  input  wire                   rst,
  carry_bypass_adder_if.slave   bus
);

  localparam int c_NUM_BLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  logic [WIDTH-1:0] r_f;
  logic             r_cout;

  assign w_p = bus.A ^ bus.B;
  assign w_g = bus.A & bus.B;

  // Block-wise ripple add; each block's carry-out bypasses to its carry-in
  // when every bit in the block propagates. Both paths give the same value,
  // the bypass only shortens the critical path.
  always_comb begin
    logic w_carry;
    logic w_blk_cin;
    logic w_ripple;
    logic w_blk_p;
    w_sum     = '0;
    w_carry   = bus.Cin;
    w_blk_cin = 1'b0;
    w_ripple  = 1'b0;
    w_blk_p   = 1'b0;
    for (int k = 0; k < c_NUM_BLK; k++) begin
      w_blk_cin = w_carry;
      w_ripple  = w_carry;
      w_blk_p   = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        w_sum[k*BLOCK + j] = w_p[k*BLOCK + j] ^ w_ripple;
        w_ripple           = w_g[k*BLOCK + j] | (w_p[k*BLOCK + j] & w_ripple);
        w_blk_p            = w_blk_p & w_p[k*BLOCK + j];
      end
      w_carry = w_blk_p ? w_blk_cin : w_ripple;
    end
    w_cout = w_carry;
  end

  // Output register: reset wins over the sum captured at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_f    <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign bus.F    = r_f;
  assign bus.Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_carry_bypass_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_carry_bypass_adder
// Description : Self-checking bench for carry_bypass_adder. Each cycle a new
//               operand set is applied; the result one edge later is compared
//               with the plain arithmetic sum A + B + Cin (or zero if reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_bypass_adder;

  localparam int WIDTH = 32;
  localparam int BLOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  carry_bypass_adder_if #(.WIDTH(WIDTH)) bus ();

  carry_bypass_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed {Cout, F} against its expected value.
  task automatic check_eq(input string tag, input logic [WIDTH:0] obs,
                          input logic [WIDTH:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got Cout/F=%h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one operand set (and reset level), clock it in, then check the
  // registered result against the reference sum.
  task automatic step(input string tag, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic cin,
                      input logic r);
    logic [WIDTH:0] exp;
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) exp = '0;
    else   exp = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    check_eq(tag, {bus.Cout, bus.F}, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rr;

    bus.A   = '1;
    bus.B   = '1;
    bus.Cin = 1'b1;

    // Reset holds outputs at zero regardless of the operands.
    step("reset0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    step("reset1", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);

    // Directed corner cases, back to back.
    step("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    step("neg_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step("100m50",     32'd100,       32'hFFFF_FFCE, 1'b0, 1'b0);
    step("10p15c",     32'd10,        32'd15,        1'b1, 1'b0);
    step("m10m5c",     32'hFFFF_FFF6, 32'hFFFF_FFFB, 1'b1, 1'b0);
    step("bypass_c1",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    step("bypass_c0",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    step("alt_prop",   32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    step("zero",       32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    step("max_all",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step("blk_prop",   32'h0F0F_0F0F, 32'h00F0_00F0, 1'b1, 1'b0);

    // Reset in mid-stream discards that edge's result, then sums resume.
    step("mid_rst",    32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
    step("resume",     32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);

    // Random vectors, with a bias toward long propagate runs and rare resets.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       rb = ~ra ^ (32'h1 << $urandom_range(0, WIDTH-1));
        default: rb = $urandom;
      endcase
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 63) == 0);
      step("rand", ra, rb, rc, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
